// File: rtl/fetch_pc_stage_pkg.sv
// Shared CPU constants and helpers for the fetch stage.
// Holds the reset PC, the bubble instruction and the jump-target formation rule.
package fetch_pc_stage_pkg;

    localparam int PC_W = 32;
    localparam int INSTR_W = 32;

    localparam logic [PC_W-1:0]    RESET_PC_DEFAULT  = 32'h0000_3000;
    localparam logic [INSTR_W-1:0] NOP_INSTR_DEFAULT = 32'h0000_0000;

    // j/jal target: PC+4 region bits of the ID instruction plus word-shifted index
    function automatic logic [PC_W-1:0] jumpTarget(input logic [3:0] pcRegion,
                                                   input logic [25:0] jIndex);
        return {pcRegion, jIndex, 2'b00};
    endfunction

endpackage

// File: rtl/fetch_pc_stage_npc_sel.sv
// Next-PC selection for the fetch stage.
// Purely combinational; jr beats jump beats a taken branch beats sequential fetch.
module npc_sel
    import fetch_pc_stage_pkg::*;
(
    input  logic [PC_W-1:0] pcF,
    input  logic [3:0]      pc4Region,
    input  logic [25:0]     jIndex,
    input  logic            jr,
    input  logic [PC_W-1:0] pcjr,
    input  logic            jump,
    input  logic            brTaken,
    input  logic [PC_W-1:0] brTarget,
    output logic [PC_W-1:0] nextPc
);

    always_comb begin
        nextPc = pcF + 32'd4;
        if (jr) begin
            nextPc = pcjr;
        end else if (jump) begin
            nextPc = jumpTarget(pc4Region, jIndex);
        end else if (brTaken) begin
            nextPc = brTarget;
        end
    end

endmodule

// File: rtl/fetch_pc_stage.sv
// Fetch stage: PC register, next-PC selection and the IF/ID pipeline register.
// Redirects come from ID, so the instruction in IF is the delay slot and is never squashed.
module fetch_pc_stage
    import fetch_pc_stage_pkg::*;
#(
    parameter logic [PC_W-1:0]    RESET_PC  = RESET_PC_DEFAULT,
    parameter logic [INSTR_W-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic               clr_d,
    input  logic [INSTR_W-1:0] instr_f,
    input  logic               br_taken,
    input  logic [PC_W-1:0]    br_target,
    input  logic               jump,
    input  logic               jr,
    input  logic [PC_W-1:0]    pcjr,
    output logic [PC_W-1:0]    pc_f,
    output logic [INSTR_W-1:0] instr_d,
    output logic [PC_W-1:0]    pc_d,
    output logic [PC_W-1:0]    pc4_d,
    output logic [PC_W-1:0]    pc8_d,
    output logic               valid_d,
    output logic               adel_f
);

    logic [PC_W-1:0] nextPc;

    npc_sel uNpcSel (
        .pcF       (pc_f),
        .pc4Region (pc4_d[31:28]),
        .jIndex    (instr_d[25:0]),
        .jr        (jr),
        .pcjr      (pcjr),
        .jump      (jump),
        .brTaken   (br_taken),
        .brTarget  (br_target),
        .nextPc    (nextPc)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_f <= RESET_PC;
        end else if (!stall) begin
            pc_f <= nextPc;
        end
    end

    // An exception flush clears IF/ID even while the hazard unit is stalling
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr_d <= NOP_INSTR;
            pc_d    <= '0;
            pc4_d   <= '0;
            pc8_d   <= '0;
            valid_d <= 1'b0;
        end else if (clr_d) begin
            instr_d <= NOP_INSTR;
            pc_d    <= '0;
            pc4_d   <= '0;
            pc8_d   <= '0;
            valid_d <= 1'b0;
        end else if (!stall) begin
            instr_d <= instr_f;
            pc_d    <= pc_f;
            pc4_d   <= pc_f + 32'd4;
            pc8_d   <= pc_f + 32'd8;
            valid_d <= 1'b1;
        end
    end

    // Misaligned targets are not masked; the exception logic decides
    assign adel_f = (pc_f[1:0] != 2'b00);

endmodule

// File: tb/tb_fetch_pc_stage.sv
// Self-checking bench for fetch_pc_stage.
// Expected IF/ID and PC state is pushed to a scoreboard when stimulus is driven and popped after the edge.
module tb_fetch_pc_stage;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instrD;
        logic [31:0] pcD;
        logic [31:0] pc4D;
        logic [31:0] pc8D;
        logic        valid;
        logic        adel;
    } expT;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        clr_d;
    logic [31:0] instr_f;
    logic        br_taken;
    logic [31:0] br_target;
    logic        jump;
    logic        jr;
    logic [31:0] pcjr;
    logic [31:0] pc_f;
    logic [31:0] instr_d;
    logic [31:0] pc_d;
    logic [31:0] pc4_d;
    logic [31:0] pc8_d;
    logic        valid_d;
    logic        adel_f;

    int compareCount = 0;
    int failCount    = 0;

    expT sbQ[$];

    logic [31:0] mPc;
    logic [31:0] mInstrD;
    logic [31:0] mPcD;
    logic [31:0] mPc4D;
    logic [31:0] mPc8D;
    logic        mValid;

    fetch_pc_stage dut (
        .clk       (clk),
        .reset     (reset),
        .stall     (stall),
        .clr_d     (clr_d),
        .instr_f   (instr_f),
        .br_taken  (br_taken),
        .br_target (br_target),
        .jump      (jump),
        .jr        (jr),
        .pcjr      (pcjr),
        .pc_f      (pc_f),
        .instr_d   (instr_d),
        .pc_d      (pc_d),
        .pc4_d     (pc4_d),
        .pc8_d     (pc8_d),
        .valid_d   (valid_d),
        .adel_f    (adel_f)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Small instruction memory: a j with index 0xC10 at 0x3004, tagged filler elsewhere
    function automatic logic [31:0] imem(input logic [31:0] addr);
        if (addr == 32'h0000_3004) return 32'h0800_0C10;
        return {16'h2400, addr[15:0]};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        compareCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    task automatic modelReset();
        mPc     = 32'h0000_3000;
        mInstrD = 32'h0;
        mPcD    = 32'h0;
        mPc4D   = 32'h0;
        mPc8D   = 32'h0;
        mValid  = 1'b0;
    endtask

    // Drive one cycle of inputs (called just after a falling edge), predict, then compare after the edge
    task automatic applyStimulus(input logic s, input logic c, input logic [31:0] ins,
                                 input logic b, input logic [31:0] bt,
                                 input logic j, input logic r, input logic [31:0] pj);
        logic [31:0] nPc;
        expT e;
        expT got;
        stall = s; clr_d = c; instr_f = ins; br_taken = b; br_target = bt;
        jump = j; jr = r; pcjr = pj;
        if (r)      nPc = pj;
        else if (j) nPc = {mPc4D[31:28], mInstrD[25:0], 2'b00};
        else if (b) nPc = bt;
        else        nPc = mPc + 32'd4;
        if (c) begin
            mInstrD = 32'h0; mPcD = 32'h0; mPc4D = 32'h0; mPc8D = 32'h0; mValid = 1'b0;
        end else if (!s) begin
            mInstrD = ins; mPcD = mPc; mPc4D = mPc + 32'd4; mPc8D = mPc + 32'd8; mValid = 1'b1;
        end
        if (!s) mPc = nPc;
        e.pc = mPc; e.instrD = mInstrD; e.pcD = mPcD; e.pc4D = mPc4D; e.pc8D = mPc8D;
        e.valid = mValid; e.adel = (mPc[1:0] != 2'b00);
        sbQ.push_back(e);
        @(posedge clk);
        #1;
        got = sbQ.pop_front();
        checkOutput("pc_f",    pc_f,           got.pc);
        checkOutput("instr_d", instr_d,        got.instrD);
        checkOutput("pc_d",    pc_d,           got.pcD);
        checkOutput("pc4_d",   pc4_d,          got.pc4D);
        checkOutput("pc8_d",   pc8_d,          got.pc8D);
        checkOutput("valid_d", {31'b0, valid_d}, {31'b0, got.valid});
        checkOutput("adel_f",  {31'b0, adel_f},  {31'b0, got.adel});
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; clr_d = 1'b0; instr_f = 32'h0; br_taken = 1'b0;
        br_target = 32'h0; jump = 1'b0; jr = 1'b0; pcjr = 32'h0;
        modelReset();
        #3;
        checkOutput("rst pc_f",    pc_f,    32'h0000_3000);
        checkOutput("rst instr_d", instr_d, 32'h0);
        checkOutput("rst pc8_d",   pc8_d,   32'h0);
        checkOutput("rst valid_d", {31'b0, valid_d}, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // Sequential fetch, then the j at 0x3004 reaches ID and redirects with its delay slot
        applyStimulus(0, 0, imem(mPc), 0, 32'h0, 0, 0, 32'h0);
        checkOutput("seq pc8_d first", pc8_d, 32'h0000_3008);
        applyStimulus(0, 0, imem(mPc), 0, 32'h0, 0, 0, 32'h0);
        checkOutput("seq pc_f 3008", pc_f, 32'h0000_3008);
        applyStimulus(0, 0, imem(mPc), 0, 32'h0, 1, 0, 32'h0);
        checkOutput("j target", pc_f, 32'h0000_3040);
        checkOutput("j delay slot", instr_d, 32'h2400_3008);
        checkOutput("j pc8_d", pc8_d, 32'h0000_3010);

        // All redirects at once: jr has priority
        applyStimulus(0, 0, imem(mPc), 1, 32'h5555_0000, 1, 1, 32'h0000_4000);
        checkOutput("prio jr", pc_f, 32'h0000_4000);
        applyStimulus(0, 0, imem(mPc), 0, 32'h0, 0, 0, 32'h0);

        // Flush: IF/ID clears while PC advances; with stall too, PC holds
        applyStimulus(0, 1, 32'h8C01_0004, 0, 32'h0, 0, 0, 32'h0);
        checkOutput("clr instr_d", instr_d, 32'h0);
        checkOutput("clr pc_f", pc_f, 32'h0000_4008);
        applyStimulus(1, 1, imem(mPc), 0, 32'h0, 0, 0, 32'h0);
        applyStimulus(0, 0, imem(mPc), 0, 32'h0, 0, 0, 32'h0);

        // Stalled branch is ignored until the stall releases
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 0, imem(mPc), 1, 32'h0000_5000, 0, 0, 32'h0);
        end
        checkOutput("stall pc_f", pc_f, 32'h0000_400C);
        applyStimulus(0, 0, imem(mPc), 1, 32'h0000_5000, 0, 0, 32'h0);
        checkOutput("br after stall", pc_f, 32'h0000_5000);

        // Asynchronous reset in the middle of a stall cycle
        stall = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        modelReset();
        checkOutput("async pc_f",    pc_f,    32'h0000_3000);
        checkOutput("async instr_d", instr_d, 32'h0);
        checkOutput("async valid_d", {31'b0, valid_d}, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // Misaligned jr target is loaded as-is and flagged; then PC wrap-around
        applyStimulus(0, 0, imem(mPc), 0, 32'h0, 0, 1, 32'h0000_3002);
        checkOutput("adel misaligned", {31'b0, adel_f}, 32'h1);
        applyStimulus(0, 0, imem(mPc), 0, 32'h0, 0, 1, 32'hFFFF_FFFC);
        applyStimulus(0, 0, imem(mPc), 0, 32'h0, 0, 0, 32'h0);
        checkOutput("wrap pc_f", pc_f, 32'h0);
        checkOutput("wrap pc8_d", pc8_d, 32'h0000_0004);
        applyStimulus(0, 0, imem(mPc), 0, 32'h0, 0, 0, 32'h0);

        checkOutput("sb empty", sbQ.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

endmodule
